// File: rtl/nios_pio_in_conditioner.sv
// Per-bit synchronizer and debouncer for PIO inputs.
// Each bit produces a debounced level, rise/fall pulses, and a shared change strobe.

module nios_pio_in_conditioner_lane #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter int   CNT_W           = 2,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic data,
    output logic rise,
    output logic fall,
    output logic change_d
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             data_q, data_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        // Any agreeing sample restarts qualification, so glitches never accumulate.
        if (s2_q != data_q) begin
            if (cnt_q == CNT_MAX) begin
                data_d = s2_q;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= RESET_BIT;
            s2_q   <= RESET_BIT;
            data_q <= RESET_BIT;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign data     = data_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign change_d = rise_d | fall_d;
endmodule

module nios_pio_in_conditioner #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);
    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] change_d;
    logic             any_change_q, any_change_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        nios_pio_in_conditioner_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RESET_BIT       (RESET_VALUE[i])
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw      (raw_in[i]),
            .data     (data_out[i]),
            .rise     (rise[i]),
            .fall     (fall[i]),
            .change_d (change_d[i])
        );
    end

    // Built from the lanes' next-state strobes so it lines up with the pulses.
    always_comb begin
        any_change_d = |change_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) any_change_q <= 1'b0;
        else          any_change_q <= any_change_d;
    end

    assign any_change = any_change_q;
endmodule

// File: tb/tb_nios_pio_in_conditioner.sv
// Directed vector bench for nios_pio_in_conditioner with a 4-cycle debounce window.

module tb_nios_pio_in_conditioner;
    typedef struct {
        logic [7:0] raw;
        logic [7:0] data;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       any;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] raw_in = 8'h00;
    logic [7:0] data_out, rise, fall;
    logic       any_change;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    nios_pio_in_conditioner #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4),
        .RESET_VALUE     (8'h00)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .raw_in     (raw_in),
        .data_out   (data_out),
        .rise       (rise),
        .fall       (fall),
        .any_change (any_change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] d, input logic [7:0] r,
                       input logic [7:0] f, input logic a);
        n_tests++;
        if (data_out !== d || rise !== r || fall !== f || any_change !== a) begin
            n_fail++;
            $display("FAIL %s: got data=%h rise=%h fall=%h any=%b, want data=%h rise=%h fall=%h any=%b",
                     name, data_out, rise, fall, any_change, d, r, f, a);
        end
    endtask

    task automatic hold(input logic [7:0] raw, input logic [7:0] d, input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.raw = raw; v.data = d; v.rise = 8'h00; v.fall = 8'h00; v.any = 1'b0;
            vecs.push_back(v);
        end
    endtask

    task automatic pulse(input logic [7:0] raw, input logic [7:0] d, input logic [7:0] r,
                         input logic [7:0] f);
        vec_t v;
        v.raw = raw; v.data = d; v.rise = r; v.fall = f; v.any = 1'b1;
        vecs.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Steady input, then a clean step: output changes 5 edges after the s1 capture.
        hold(8'h00, 8'h00, 3);
        hold(8'h01, 8'h00, 5); pulse(8'h01, 8'h01, 8'h01, 8'h00); hold(8'h01, 8'h01, 1);
        hold(8'hFF, 8'h01, 5); pulse(8'hFF, 8'hFF, 8'hFE, 8'h00); hold(8'hFF, 8'hFF, 1);
        hold(8'h7F, 8'hFF, 5); pulse(8'h7F, 8'h7F, 8'h00, 8'h80); hold(8'h7F, 8'h7F, 1);
        hold(8'h00, 8'h7F, 5); pulse(8'h00, 8'h00, 8'h00, 8'h7F); hold(8'h00, 8'h00, 1);
        hold(8'h81, 8'h00, 5); pulse(8'h81, 8'h81, 8'h81, 8'h00); hold(8'h81, 8'h81, 1);
        hold(8'h80, 8'h81, 5); pulse(8'h80, 8'h80, 8'h00, 8'h01); hold(8'h80, 8'h80, 1);
        // Bit0 bounce 1,0,1,0 then held 1: only the final stable run qualifies.
        hold(8'h81, 8'h80, 1); hold(8'h80, 8'h80, 1);
        hold(8'h81, 8'h80, 1); hold(8'h80, 8'h80, 1);
        hold(8'h81, 8'h80, 5); pulse(8'h81, 8'h81, 8'h01, 8'h00); hold(8'h81, 8'h81, 2);
        // 3-cycle glitch on bit2 reaches count 3 but never loads.
        hold(8'h85, 8'h81, 3); hold(8'h81, 8'h81, 6);

        tick();
        chk("reset_state", 8'h00, 8'h00, 8'h00, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            raw_in = vecs[i].raw;
            tick();
            chk($sformatf("vec%0d", i), vecs[i].data, vecs[i].rise, vecs[i].fall, vecs[i].any);
        end

        // Asynchronous reset clears a non-zero level before the next edge.
        reset_n = 1'b0;
        #1;
        chk("async_reset", 8'h00, 8'h00, 8'h00, 1'b0);
        raw_in = 8'h00;
        tick();
        reset_n = 1'b1;
        tick();
        tick();

        // Reset asserted after two counts discards the partial qualification.
        raw_in = 8'h01;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_reset_count", 8'h00, 8'h00, 8'h00, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_count_reset", 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i < 6)       chk($sformatf("post_rel%0d", i), 8'h00, 8'h00, 8'h00, 1'b0);
            else if (i == 6) chk("post_rel6", 8'h01, 8'h01, 8'h00, 1'b1);
            else             chk("post_rel7", 8'h01, 8'h00, 8'h00, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/nios_pio_in_conditioner.md
NIOS_PIO_IN_CONDITIONER -- requirements
Module: nios_pio_in_conditioner

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of independent input channels; it matches the PIO in_port width.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the number of consecutive disagreeing samples needed to accept a new level; legal range 1..65535.
REQ-003 Parameter RESET_VALUE, default 8'h00 (WIDTH bits), SHALL set the reset value of the synchronizers and of the accepted level.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous active-low reset; assertion SHALL clear state immediately, and release SHALL take effect on the next clk edge.
REQ-006 Port raw_in, input, WIDTH bits: asynchronous buttons or switches, possibly bouncing.
REQ-007 Port data_out, output, WIDTH bits: debounced level, registered; it drives the PIO in_port.
REQ-008 Port rise, output, WIDTH bits: one-cycle pulse per bit when data_out goes from 0 to 1.
REQ-009 Port fall, output, WIDTH bits: one-cycle pulse per bit when data_out goes from 1 to 0.
REQ-010 Port any_change, output, 1 bit: OR of (rise | fall), registered in the same cycle as the pulses.

Function
REQ-011 Each bit SHALL pass through a two-flop synchronizer, s1 then s2, before any other logic; there SHALL be no combinational path from raw_in to any output.
REQ-012 Each bit SHALL own a counter of ceil(log2(DEBOUNCE_CYCLES)) bits, minimum 1, that is independent of all other bits.
REQ-013 On each edge, if s2 == data_out, that bit's counter SHALL clear to 0; a glitch shorter than the window therefore restarts qualification.
REQ-014 On each edge, if s2 != data_out and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-015 On each edge, if s2 != data_out and counter == DEBOUNCE_CYCLES-1, then data_out SHALL load s2 and the counter SHALL clear; the counter SHALL never wrap past DEBOUNCE_CYCLES-1.
REQ-016 rise or fall for a bit SHALL assert on the same edge that data_out changes, for exactly one cycle, and SHALL deassert on the next edge.
REQ-017 Latency: a clean level change captured by s1 at edge k SHALL appear on data_out at edge k+1+DEBOUNCE_CYCLES.
REQ-018 A steady input SHALL never produce a pulse; rise and fall SHALL never both be high for the same bit.
REQ-019 Bits that qualify on the same edge SHALL update and pulse together, and any_change SHALL be a single-cycle pulse covering all of them.
REQ-020 A bit that keeps toggling with a period shorter than the window SHALL hold data_out at its old value indefinitely.

Reset
REQ-021 While reset_n = 0: s1, s2 and data_out = RESET_VALUE; all counters = 0; rise = fall = 0; any_change = 0.
REQ-022 Reset asserted mid-qualification SHALL discard the partial count; after release, qualification SHALL restart from 0 with no pulse emitted.
REQ-023 After release, if raw_in differs from RESET_VALUE, the bit SHALL qualify normally per REQ-017 and pulse once.

Verification (DEBOUNCE_CYCLES = 4, WIDTH = 8, RESET_VALUE = 0)
REQ-024 Clean step: raw_in 00 -> 01, captured by s1 at edge k -> data_out = 01 and rise = 01 at edge k+5 only; any_change high for 1 cycle; fall = 00 throughout.
REQ-025 Bounce: bit0 pattern 1,0,1,0,1 at one cycle each, then held 1 -> no change until 4 consecutive agreeing s2 samples; exactly one rise pulse.
REQ-026 Release: with data_out = FF, raw_in -> 7F and held -> data_out = 7F and fall = 80 for one cycle; rise = 00.
REQ-027 Simultaneous: raw_in 00 -> 81 on one edge -> rise = 81 on a single edge; any_change single pulse.
REQ-028 Reset mid-count: raw_in = 01, reset_n pulsed low after 2 counts -> outputs 00 immediately; after release data_out = 01 at release edge + 6 (re-synchronize plus full window).
REQ-029 Glitch: 3-cycle high pulse on bit2 from steady 0 -> data_out bit2 stays 0; no rise or fall on any bit.
